// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } cam_state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

endpackage

// File: rtl/cam_capture_if.sv
// Camera bus and frame-buffer write port; master drives the camera side, slave is the capture block.
interface cam_capture_if #(
  parameter int ADDR_W = 19
);
  import cam_pkg::*;

  logic              PCLK;
  logic              CamHsync;
  logic              CamVsync;
  logic [7:0]        CamData;
  logic              Enable;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [PIX_W-1:0]  WrData;
  logic              FrameDone;
  logic              FrameErr;

  modport master (
    output PCLK, CamHsync, CamVsync, CamData, Enable,
    input  WrEn, WrAddr, WrData, FrameDone, FrameErr
  );

  modport slave (
    input  PCLK, CamHsync, CamVsync, CamData, Enable,
    output WrEn, WrAddr, WrData, FrameDone, FrameErr
  );

endinterface

// File: rtl/cam_edge_sync.sv
// Three-stage synchronizer: q is the second stage, rise/fall compare stages two and three.
module cam_edge_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/cam_capture.sv
// Oversamples an 8-bit camera bus and writes RGB565 pixels with linear addresses.
// Optional 2:1 decimation in both axes when CAM_CAPTURE_DECIM_EN is defined.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic          CLK,
  input  logic          RST_N,
  cam_capture_if.slave  cam
);

  localparam int CW = 16;
  localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_LIM = CW'(V_ACTIVE);
`ifdef CAM_CAPTURE_DECIM_EN
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE);
`endif

  logic pclk_q, pclk_rise, pclk_fall;
  logic href_s2, href_rise, href_fall;
  logic vs_q, vs_rise, vs_fall;
  logic [7:0] data_s1, data_s2;

  cam_edge_sync #(.W(1)) u_pclk_sync (
    .clk(CLK), .rst_n(RST_N), .d(cam.PCLK), .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall));
  cam_edge_sync #(.W(1)) u_href_sync (
    .clk(CLK), .rst_n(RST_N), .d(cam.CamHsync), .q(href_s2), .rise(href_rise), .fall(href_fall));
  cam_edge_sync #(.W(1)) u_vs_sync (
    .clk(CLK), .rst_n(RST_N), .d(cam.CamVsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall));

  logic unused_edges;
  assign unused_edges = ^{pclk_q, pclk_fall, href_rise, vs_q};

  cam_state_t        state, state_n;
  logic [CW-1:0]     x, x_n, y, y_n;
  logic              phase, phase_n, line_pend, pend_n, err, err_n, clr;
  logic [7:0]        hi_byte, hi_n;
  logic [ADDR_W-1:0] addr, addr_n, row_base, row_n, wr_addr, wr_addr_n;
  logic [PIX_W-1:0]  wr_data, wr_data_n;
  logic              wr_en, wr_en_n, done, done_n, keep, row_step;

`ifdef CAM_CAPTURE_DECIM_EN
  assign keep     = ~x[0] & ~y[0];
  assign row_step = ~y[0];
`else
  assign keep     = 1'b1;
  assign row_step = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_s1   <= '0;
      data_s2   <= '0;
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      phase     <= 1'b0;
      line_pend <= 1'b0;
      hi_byte   <= '0;
      addr      <= '0;
      row_base  <= '0;
      err       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
    end else begin
      data_s1   <= cam.CamData;
      data_s2   <= data_s1;
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      phase     <= phase_n;
      line_pend <= pend_n;
      hi_byte   <= hi_n;
      addr      <= addr_n;
      row_base  <= row_n;
      err       <= err_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    phase_n   = phase;
    pend_n    = 1'b0;
    hi_n      = hi_byte;
    addr_n    = addr;
    row_n     = row_base;
    err_n     = err;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise && cam.Enable) begin
          state_n = ARMED;
          clr     = 1'b1;
        end
      end
      ARMED: begin
        // Error flag stays visible through FrameDone; it clears as the new frame begins.
        if (vs_fall) begin
          state_n = CAPTURE;
          err_n   = 1'b0;
        end
      end
      CAPTURE: begin
        if (line_pend || (href_fall && !pclk_rise)) begin
          if (phase || (x != H_LIM)) err_n = 1'b1;
          if ((y < V_LIM) && row_step) row_n = row_base + STRIDE;
          addr_n  = row_n;
          x_n     = '0;
          y_n     = (y == '1) ? y : y + CW'(1);
          phase_n = 1'b0;
        end else if (pclk_rise && (href_s2 || href_fall)) begin
          // A byte coinciding with HREF falling still counts; its line end follows next cycle.
          pend_n = href_fall;
          if (!phase) begin
            hi_n    = data_s2;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if ((x < H_LIM) && (y < V_LIM) && keep) begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr;
              wr_data_n = {hi_byte, data_s2};
              addr_n    = addr + ADDR_W'(1);
            end
            x_n = (x == '1) ? x : x + CW'(1);
          end
        end
        if (vs_rise) begin
          if (y != V_LIM) err_n = 1'b1;
          done_n  = 1'b1;
          state_n = cam.Enable ? ARMED : IDLE;
          clr     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      x_n     = '0;
      y_n     = '0;
      phase_n = 1'b0;
      pend_n  = 1'b0;
      addr_n  = '0;
      row_n   = '0;
    end
  end

  assign cam.WrEn      = wr_en;
  assign cam.WrAddr    = wr_addr;
  assign cam.WrData    = wr_data;
  assign cam.FrameDone = done;
  assign cam.FrameErr  = err;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture (H_ACTIVE=4, V_ACTIVE=2, CLK = 4x PCLK) with a byte-level reference model.
module tb_cam_capture;
  import cam_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cam_capture_if #(.ADDR_W(AW)) cam ();

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .CLK(clk), .RST_N(rst_n), .cam(cam));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+15:0] exp_wr[$];
  bit             exp_done[$];
  logic [AW+15:0] log_wr[$];
  bit             log_done[$];

  int       m_cap, m_x, m_y, m_phase, m_err, byte_idx;
  logic [7:0] m_hi;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_val(input int k);
    logic [3:0] a, b;
    a = 4'((2 * k + 1) % 16);
    b = 4'((2 * k + 2) % 16);
    return {a, b};
  endfunction

  // Model: which bytes become which pixels at which address, per the framing rules.
  task automatic model_byte(input logic [7:0] b);
    int a;
    bit keep;
    if (m_cap == 0) return;
    if (m_phase == 0) begin
      m_hi    = b;
      m_phase = 1;
    end else begin
      m_phase = 0;
`ifdef CAM_CAPTURE_DECIM_EN
      keep = (m_x % 2 == 0) && (m_y % 2 == 0);
      a    = (m_y / 2) * (H / 2) + m_x / 2;
`else
      keep = 1'b1;
      a    = m_y * H + m_x;
`endif
      if (m_x < H && m_y < V && keep) exp_wr.push_back({AW'(a), m_hi, b});
      m_x++;
    end
  endtask

  task automatic pclk_cyc(input logic href, input logic vs, input logic [7:0] d);
    cam.PCLK = 1'b0; cam.CamHsync = href; cam.CamVsync = vs; cam.CamData = d;
    #20;
    cam.PCLK = 1'b1;
    #20;
  endtask

  task automatic send_bytes(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = byte_val(byte_idx);
      byte_idx++;
      model_byte(b);
      pclk_cyc(1'b1, 1'b0, b);
    end
  endtask

  task automatic end_line();
    if (m_cap != 0) begin
      if (m_phase != 0 || m_x != H) m_err = 1;
      m_x = 0; m_y++; m_phase = 0;
    end
    repeat (3) pclk_cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync();
    if (m_cap != 0) begin
      if (m_y != V) m_err = 1;
      exp_done.push_back(m_err[0]);
    end
    m_cap = cam.Enable ? 1 : 0;
    m_x = 0; m_y = 0; m_phase = 0; m_err = 0; byte_idx = 0;
    repeat (2) pclk_cyc(1'b0, 1'b1, 8'h00);
    repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_wr_left"}, exp_wr.size(), 0);
    chk({nm, "_done_left"}, exp_done.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cam.WrEn) begin
        log_wr.push_back({cam.WrAddr, cam.WrData});
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required (t=%0t)",
                   cam.WrAddr, cam.WrData, $time);
        end else begin
          logic [AW+15:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", cam.WrAddr, e[AW+15:16]);
          chk("wr_data", cam.WrData, e[15:0]);
        end
      end
      if (cam.FrameDone) begin
        log_done.push_back(cam.FrameErr);
        if (exp_done.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame_done: FrameErr %0b, no FrameDone required (t=%0t)",
                   cam.FrameErr, $time);
        end else begin
          chk("frame_err", cam.FrameErr, exp_done.pop_front());
        end
      end
    end
  end

  task automatic clear_logs();
    log_wr.delete();
    log_done.delete();
  endtask

  initial begin
    cam.PCLK = 1'b0; cam.CamHsync = 1'b0; cam.CamVsync = 1'b0;
    cam.CamData = 8'h00; cam.Enable = 1'b0;
    m_cap = 0; m_x = 0; m_y = 0; m_phase = 0; m_err = 0; byte_idx = 0; m_hi = 8'h00;
    #22;
    chk("rst_wr_en", cam.WrEn, 0);
    chk("rst_wr_addr", cam.WrAddr, 0);
    chk("rst_wr_data", cam.WrData, 0);
    chk("rst_frame_done", cam.FrameDone, 0);
    chk("rst_frame_err", cam.FrameErr, 0);
    #10 rst_n = 1'b1;
    repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);

    // Nominal frame: two lines of 8 bytes.
    clear_logs();
    cam.Enable = 1'b1; vsync();
    send_bytes(8); end_line(); send_bytes(8); end_line();
    cam.Enable = 1'b0; vsync();
    drained("nominal");
    chk("nominal_done_count", log_done.size(), 1);
    chk("nominal_done_err", log_done[0], 0);
`ifdef CAM_CAPTURE_DECIM_EN
    chk("decim_wr_count", log_wr.size(), 2);
    chk("decim_wr0", log_wr[0], {19'd0, 16'h1234});
    chk("decim_wr1", log_wr[1], {19'd1, 16'h9ABC});
`else
    chk("nominal_wr_count", log_wr.size(), 8);
    chk("nominal_wr0", log_wr[0], {19'd0, 16'h1234});
    chk("nominal_wr3", log_wr[3], {19'd3, 16'hDEF0});
    chk("nominal_wr7", log_wr[7], {19'd7, 16'hDEF0});
`endif

    // Odd byte count on line 0.
    clear_logs();
    cam.Enable = 1'b1; vsync();
    send_bytes(9); end_line(); send_bytes(8); end_line();
    cam.Enable = 1'b0; vsync();
    drained("odd");
    chk("odd_done_err", log_done[0], 1);
`ifndef CAM_CAPTURE_DECIM_EN
    chk("odd_wr_count", log_wr.size(), 8);
`endif

    // Overlong first line (6 pixels).
    clear_logs();
    cam.Enable = 1'b1; vsync();
    send_bytes(12); end_line(); send_bytes(8); end_line();
    cam.Enable = 1'b0; vsync();
    drained("long");
    chk("long_done_err", log_done[0], 1);
`ifndef CAM_CAPTURE_DECIM_EN
    chk("long_wr_count", log_wr.size(), 8);
    chk("long_wr3", log_wr[3], {19'd3, 16'hDEF0});
    chk("long_line1_start", log_wr[4], {19'd4, 16'h9ABC});
`endif

    // Enable dropped mid-frame, then a frame that must be ignored.
    clear_logs();
    cam.Enable = 1'b1; vsync();
    send_bytes(8); end_line();
    cam.Enable = 1'b0;
    send_bytes(8); end_line();
    vsync();
    send_bytes(8); end_line(); send_bytes(8); end_line();
    vsync();
    drained("endrop");
    chk("endrop_done_count", log_done.size(), 1);
    chk("endrop_done_err", log_done[0], 0);

    // Reset in the middle of a line.
    cam.Enable = 1'b1; vsync();
    send_bytes(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", cam.WrEn, 0);
    chk("midrst_wr_addr", cam.WrAddr, 0);
    chk("midrst_wr_data", cam.WrData, 0);
    chk("midrst_frame_done", cam.FrameDone, 0);
    chk("midrst_frame_err", cam.FrameErr, 0);
    m_cap = 0; exp_wr.delete(); exp_done.delete();
    clear_logs();
    #9 rst_n = 1'b1;
    send_bytes(5); end_line(); send_bytes(8); end_line();
    chk("midrst_no_write", log_wr.size(), 0);
    vsync();
    send_bytes(8); end_line(); send_bytes(8); end_line();
    cam.Enable = 1'b0; vsync();
    drained("midrst");
    chk("midrst_first_wr", log_wr[0], {19'd0, 16'h1234});
    chk("midrst_done_err", log_done[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
